// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the transmit and receive engines.
//   uart_state_e    : frame-level FSM state encoding
//   PAR_EVEN/PAR_ODD: parity type encodings on the par_typ input
//   UART_DATA_WIDTH : default payload bits per frame
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte hand-off channel into the UART transmitter.
//   p_data     : byte to send (master -> slave)
//   data_valid : request to send p_data (master -> slave)
//   tx_ready   : slave can take a byte (slave -> master)
// Handshake: a byte moves on any rising clk edge where data_valid && tx_ready.
// The master holds p_data stable while data_valid is high and not yet accepted;
// the slave raises tx_ready only when idle and never queues a request.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  tx_ready;

    modport master (
        output p_data,
        output data_valid,
        input  tx_ready
    );

    modport slave (
        input  p_data,
        input  data_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_parity_gen.sv
// Combinational parity generator.
//   data_i     : payload bits
//   par_typ_i  : PAR_EVEN or PAR_ODD
//   par_bit_o  : bit that makes the ones count over data+parity even (PAR_EVEN)
//                or odd (PAR_ODD)
module uart_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    always_comb begin
        par_bit_o = 1'b0;
        case (par_typ_i)
            PAR_EVEN: par_bit_o = ^data_i;
            default:  par_bit_o = ~^data_i;
        endcase
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: takes one byte per handshake and sends it LSB first as
// start bit, DATA_WIDTH data bits, optional parity bit, one stop bit.
//   clk, rst   : clock, synchronous active-high reset
//   tx_if      : slave side of the byte channel (p_data, data_valid, tx_ready)
//   par_en     : 1 = append a parity bit
//   par_typ    : PAR_EVEN / PAR_ODD
//   baud_div   : clk cycles per serial bit, 0 behaves as 1
//   tx_out     : registered serial line, idle high
//   busy       : high from the first start-bit cycle to the last stop-bit cycle
//   dbg_state  : current FSM state
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_frame_if.slave       tx_if,
    input  logic                 par_en,
    input  logic                 par_typ,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic                 tx_out,
    output logic                 busy,
    output uart_state_e          dbg_state
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [BIT_W-1:0]     BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q,   state_d;
    logic [DIV_WIDTH-1:0]  cnt_q,     cnt_d;
    logic [DIV_WIDTH-1:0]  div_q,     div_d;
    logic [BIT_W-1:0]      bit_q,     bit_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q,      tx_d;

    logic baud_last;
    logic par_bit;

    // Parity is taken from the captured byte and captured type, so config
    // changes on the inputs mid-frame cannot affect it.
    uart_parity_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i    (data_q),
        .par_typ_i (par_typ_q),
        .par_bit_o (par_bit)
    );

    // div_q is never 0 once a frame has started, so div_q-1 cannot wrap.
    assign baud_last = (cnt_q == (div_q - DIV_ONE));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                // tx_ready is high throughout IDLE, so data_valid alone accepts.
                if (tx_if.data_valid) begin
                    state_d   = START;
                    data_d    = tx_if.p_data;
                    par_en_d  = par_en;
                    par_typ_d = par_typ;
                    div_d     = (baud_div == '0) ? DIV_ONE : baud_div;
                end
            end
            default: begin
                if (baud_last) begin
                    cnt_d = '0;
                    case (state_q)
                        START: begin
                            state_d = DATA;
                            bit_d   = '0;
                        end
                        DATA: begin
                            if (bit_q == BIT_LAST) begin
                                state_d = par_en_q ? PARITY : STOP;
                                bit_d   = '0;
                            end else begin
                                bit_d = bit_q + BIT_ONE;
                            end
                        end
                        PARITY:  state_d = STOP;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
        endcase

        // The line value is computed from the next state so that tx_out comes
        // straight off a flop and changes on the same edge as the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d];
            PARITY:  tx_d = par_bit;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_ONE;
            bit_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
        end
    end

    assign tx_out         = tx_q;
    assign busy           = (state_q != IDLE);
    assign tx_if.tx_ready = (state_q == IDLE);
    assign dbg_state      = state_q;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit engine, the transmit-side counterpart of the UART_RX receiver.
- Accepts a parallel byte through a valid/ready handshake and serialises it LSB-first as one frame: start, 8 data bits, optional parity, one stop bit.
- Contains its own baud divider and parity generator.
- Parity convention matches the receiver's parity checker: even parity gives an even number of ones over data plus parity; odd parity gives an odd number.

Parameters:
DATA_WIDTH, 8, payload bits per frame
DIV_WIDTH, 16, width of baud_div input

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
p_data  input  DATA_WIDTH  byte to send
data_valid  input  1  request to send p_data
tx_ready  output  1  high only in IDLE; transfer accepted when data_valid && tx_ready
par_en  input  1  1 = include parity bit
par_typ  input  1  0 = even, 1 = odd
baud_div  input  DIV_WIDTH  clk cycles per serial bit; 0 treated as 1
tx_out  output  1  serial line, idle high
busy  output  1  high from first start-bit cycle through last stop-bit cycle

Behaviour:
- Reset (rst high at a clk edge): state IDLE, tx_out=1, busy=0, tx_ready=1, bit and baud counters cleared. Reset mid-frame aborts immediately; tx_out=1 from the next cycle and no partial frame resumes.
- Accept: in IDLE, when data_valid=1 at edge N, register p_data, par_en, par_typ and baud_div (0 becomes 1). Compute the parity bit from the registered byte: even uses ^data, odd uses ~^data.
- From cycle N+1: state START, tx_out=0, busy=1, tx_ready=0.
- Config inputs are ignored mid-frame. data_valid while tx_ready=0 is ignored and not queued.
- States:
  - IDLE -> START on accept.
  - START -> DATA.
  - DATA -> PARITY if par_en, else STOP. DATA holds DATA_WIDTH bits, index 0..DATA_WIDTH-1, LSB first.
  - PARITY -> STOP.
  - STOP -> IDLE.
- Every serial bit holds tx_out for exactly div cycles. A baud counter runs 0..div-1; the state or bit index advances when the counter hits div-1, and the counter wraps to 0.
- tx_out is registered and glitch-free, driven by state, bit index and shift register.
- Frame length in cycles = (2 + DATA_WIDTH + par_en) * div.
- After STOP ends, IDLE lasts at least 1 cycle (tx_out=1, busy=0, tx_ready=1) before the next accept. Back-to-back frames therefore have a minimum inter-frame gap of 1 clk.
- Bit-index counter width is clog2(DATA_WIDTH). The baud counter is DIV_WIDTH bits and never exceeds div-1.
- Simultaneous rst and data_valid: rst wins.

Decomposition:
- Package uart_pkg holds:
  - state encoding enum: IDLE, START, DATA, PARITY, STOP
  - constants PAR_EVEN=1'b0, PAR_ODD=1'b1
  - DATA_WIDTH default
  The UART_RX side shares the same package.
- One natural sub-module, uart_parity_gen: combinational, takes data and par_typ, outputs parity bit.
- Baud counter and FSM stay in the top module.

Test Plan:
1. p_data=0xA5, par_en=1, par_typ=0, baud_div=4.
   -> tx_out sequence 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each bit 4 cycles.
   -> busy high 44 cycles; tx_ready returns 1 on cycle 45.
2. p_data=0x01, par_en=1, par_typ=1, baud_div=2.
   -> parity bit 0; with 0x03 the parity bit is 1.
   -> frame 22 cycles.
3. p_data=0xFF, par_en=0, baud_div=0.
   -> divisor treated as 1; 10-cycle frame 0,1×8,1; no parity slot.
4. data_valid held high through a frame with p_data changing to 0x3C mid-frame.
   -> first frame unchanged; 0x3C accepted on the first idle cycle; exactly 1 idle cycle between stop and the next start bit.
5. rst asserted at data bit 3 of a 0x55 frame.
   -> next cycle tx_out=1, busy=0, tx_ready=1.
   -> new frame 0x0F then sends correctly from start bit.
6. Change baud_div 4→8 and par_typ during a frame.
   -> current frame keeps div=4 and its original parity; the next frame uses 8.
